// File: rtl/mdl_sdtx_seq_pkg.sv
// rtl/mdl_sdtx_seq_pkg.sv - shared state encoding and default sizing for the SD read-data sequencer
package mdl_sdtx_seq_pkg;

    localparam int SDTX_LGBLK = 7;
    localparam int SDTX_NAC_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NAC,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } sdtx_state_e;

endpackage

// File: rtl/sdtx_seq_fifo.sv
// rtl/sdtx_seq_fifo.sv - 2-entry synchronous word FIFO with occupancy count
module sdtx_seq_fifo #(
    parameter int DW = 32
) (
    input  logic          sd_clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count
);

    logic [DW-1:0] mem_q [2];
    logic          wr_q;
    logic          rd_q;
    logic [1:0]    cnt_q;

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (i_push) begin
                mem_q[wr_q] <= i_data;
                wr_q        <= ~wr_q;
            end
            if (i_pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_data  = mem_q[rd_q];
    assign o_count = cnt_q;

endmodule

// File: rtl/mdl_sdtx_seq.sv
// rtl/mdl_sdtx_seq.sv - card-side read-data sequencer: memory prefetch, Nac gap, block streaming, CRC drain wait
// Optional stop-at-block-boundary support is enabled by defining SDTX_SEQ_STOP_EN.
module mdl_sdtx_seq
    import mdl_sdtx_seq_pkg::*;
#(
    parameter int AW    = 10,
    parameter int LGBLK = SDTX_LGBLK,
    parameter int NAC_W = SDTX_NAC_W
) (
    input  logic             sd_clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [AW-1:0]    i_addr,
    input  logic [15:0]      i_nblocks,
    input  logic [LGBLK:0]   i_blklen,
    input  logic [NAC_W-1:0] i_nac,
    input  logic             i_stop,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [15:0]      o_blocks,
    output logic             o_mem_rd,
    output logic [AW-1:0]    o_mem_addr,
    input  logic [31:0]      i_mem_data,
    output logic             o_en,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_data,
    output logic             o_last,
    input  logic             i_tx_busy
);

    localparam logic [LGBLK:0] LEN_ONE = 1;

    sdtx_state_e      state_q;
    logic [AW-1:0]    rd_addr_q;
    logic [15:0]      nblocks_q;
    logic [LGBLK:0]   blklen_q;
    logic [NAC_W-1:0] nac_q;
    logic [NAC_W-1:0] nac_cnt_q;
    logic [LGBLK:0]   rd_left_q;
    logic [LGBLK:0]   tx_left_q;
    logic [15:0]      blocks_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             pend_q;

    logic [1:0]  fifo_cnt;
    logic [31:0] fifo_data;
    logic        valid;
    logic        pop;
    logic        issue;
    logic        stop_now;
    logic        nblk_bad;
    logic        len_bad;
    logic        nac_abort;
    logic        more_blocks;
    logic [2:0]  credit;

`ifdef SDTX_SEQ_STOP_EN
    logic stop_q;

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            stop_q <= 1'b0;
        end else begin
            stop_q <= stop_q | (busy_q & i_stop);
        end
    end

    assign stop_now = stop_q | i_stop;
    assign nblk_bad = 1'b0;
`else
    logic unused_stop;
    assign unused_stop = i_stop;
    assign stop_now    = 1'b0;
    assign nblk_bad    = (i_nblocks == 16'd0);
`endif

    // A power of two is the largest legal length, so only the top bit may be set then.
    assign len_bad = (i_blklen == '0) || (i_blklen[LGBLK] && (|i_blklen[LGBLK-1:0]));

    assign valid       = (state_q == ST_STREAM) && (fifo_cnt != 2'd0);
    assign pop         = valid && i_ready;
    assign nac_abort   = (state_q == ST_NAC) && stop_now && (rd_left_q == blklen_q);
    assign more_blocks = (nblocks_q == 16'd0) || (({1'b0, blocks_q} + 17'd1) < {1'b0, nblocks_q});

    // Credit counts the FIFO after this cycle's pop plus the word landing this cycle,
    // so a ready sink sees one word per cycle with at most two words in flight.
    assign credit = {1'b0, fifo_cnt} + {2'b0, pend_q} - {2'b0, pop};
    assign issue  = ((state_q == ST_NAC) || (state_q == ST_STREAM)) && (rd_left_q != '0)
                    && (credit < 3'd2) && !nac_abort;

    sdtx_seq_fifo #(.DW(32)) u_fifo (
        .sd_clk  (sd_clk),
        .rst_n   (rst_n),
        .i_push  (pend_q),
        .i_data  (i_mem_data),
        .i_pop   (pop),
        .o_data  (fifo_data),
        .o_count (fifo_cnt)
    );

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            nblocks_q <= '0;
            blklen_q  <= '0;
            nac_q     <= '0;
            nac_cnt_q <= '0;
            rd_left_q <= '0;
            tx_left_q <= '0;
            blocks_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            pend_q <= issue;
            done_q <= 1'b0;
            if (issue) begin
                rd_addr_q <= rd_addr_q + 1'b1;
                rd_left_q <= rd_left_q - 1'b1;
            end
            if (pop) begin
                tx_left_q <= tx_left_q - 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        rd_addr_q <= i_addr;
                        nblocks_q <= i_nblocks;
                        blklen_q  <= i_blklen;
                        nac_q     <= i_nac;
                        blocks_q  <= '0;
                        if (len_bad || nblk_bad) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            err_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            nac_cnt_q <= i_nac;
                            rd_left_q <= i_blklen;
                            tx_left_q <= i_blklen;
                            state_q   <= ST_NAC;
                        end
                    end
                end
                ST_NAC: begin
                    if (nac_abort) begin
                        state_q <= ST_DONE;
                    end else if (nac_cnt_q == '0) begin
                        state_q <= ST_STREAM;
                    end else begin
                        nac_cnt_q <= nac_cnt_q - 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (pop && (tx_left_q == LEN_ONE)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!i_tx_busy) begin
                        if (blocks_q != 16'hffff) begin
                            blocks_q <= blocks_q + 16'd1;
                        end
                        if (more_blocks && !stop_now) begin
                            nac_cnt_q <= nac_q;
                            rd_left_q <= blklen_q;
                            tx_left_q <= blklen_q;
                            state_q   <= ST_NAC;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_en       = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_blocks   = blocks_q;
    assign o_mem_rd   = issue;
    assign o_mem_addr = rd_addr_q;
    assign o_valid    = valid;
    assign o_data     = fifo_data;
    assign o_last     = valid && (tx_left_q == LEN_ONE);

endmodule

// File: tb/tb_mdl_sdtx_seq.sv
// tb/tb_mdl_sdtx_seq.sv - scoreboard bench for mdl_sdtx_seq with a randomized memory and sink
module tb_mdl_sdtx_seq;

    logic        sd_clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [9:0]  i_addr;
    logic [15:0] i_nblocks;
    logic [7:0]  i_blklen;
    logic [7:0]  i_nac;
    logic        i_stop;
    logic        o_busy, o_done, o_err, o_mem_rd, o_en, o_valid, o_last;
    logic [15:0] o_blocks;
    logic [9:0]  o_mem_addr;
    logic [31:0] i_mem_data, o_data;
    logic        i_ready, i_tx_busy;
    logic [64:0] outs;

    mdl_sdtx_seq dut (
        .sd_clk(sd_clk), .rst_n(rst_n), .i_start(i_start), .i_addr(i_addr),
        .i_nblocks(i_nblocks), .i_blklen(i_blklen), .i_nac(i_nac), .i_stop(i_stop),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_blocks(o_blocks),
        .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_en(o_en), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_last(o_last), .i_tx_busy(i_tx_busy)
    );

    assign outs = {o_busy, o_done, o_err, o_blocks, o_mem_rd, o_mem_addr,
                   o_en, o_valid, o_data, o_last};

    initial forever #5 sd_clk = ~sd_clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mem [1024];
    logic [32:0] exp_q [$];
    int          ready_mode = 0;
    int          drain_len = 0;

    int          last_hs_cyc = -1000;
    bit          rd_flag = 0;
    logic [9:0]  rd_addr = '0;
    int          rd_issued = 0, popped = 0, rd_total = 0, words_hs = 0, done_total = 0;
    int          exp_blocks = 0, blk_ref = 0, cur_nac = 0;
    bit          pending = 0, first_pending = 0, prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Sink, memory and CRC-busy drivers, all updated just after the clock edge.
    initial begin
        i_ready    = 1'b1;
        i_mem_data = '0;
        i_tx_busy  = 1'b0;
        forever begin
            @(posedge sd_clk);
            cyc++;
            #1;
            case (ready_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = (cyc % 2) == 1;
                default: i_ready = ($urandom % 4) != 0;
            endcase
            i_mem_data = rd_flag ? mem[rd_addr] : $urandom;
            i_tx_busy  = (drain_len > 0) && (cyc > last_hs_cyc) && (cyc <= last_hs_cyc + drain_len);
        end
    end

    // Monitor: scoreboard pops, stall stability, in-flight bound, block count and Nac gap.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge sd_clk);
            if (!rst_n) begin
                pending = 0; first_pending = 0; prev_stall = 0; rd_flag = 0;
                rd_issued = 0; popped = 0; exp_blocks = 0;
            end else begin
                if (i_start && !o_busy) begin
                    exp_blocks = 0; blk_ref = cyc; first_pending = 1; cur_nac = int'(i_nac);
                end
                if (o_busy) chk(o_blocks == exp_blocks[15:0], "blocks_count", o_blocks, exp_blocks);
                if (pending && !i_tx_busy) begin
                    exp_blocks++; pending = 0; blk_ref = cyc; first_pending = 1;
                end
                if (prev_stall) begin
                    chk(o_valid, "stall_valid", o_valid, 1);
                    chk(o_data == prev_data, "stall_data", o_data, prev_data);
                    chk(o_last == prev_last, "stall_last", o_last, prev_last);
                end
                if (first_pending && o_valid) begin
                    chk(cyc >= blk_ref + cur_nac + 2, "nac_gap", cyc - blk_ref, cur_nac + 2);
                    first_pending = 0;
                end
                if (o_valid && i_ready) begin
                    popped++; words_hs++;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_word", o_data, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(o_data == e[31:0], "word_data", o_data, e[31:0]);
                        chk(o_last == e[32], "word_last", o_last, e[32]);
                    end
                    if (o_last) begin
                        pending = 1; last_hs_cyc = cyc;
                    end
                end
                rd_flag = o_mem_rd;
                rd_addr = o_mem_addr;
                if (o_mem_rd) begin
                    rd_issued++; rd_total++;
                    chk(rd_issued - popped <= 2, "reads_in_flight", rd_issued - popped, 2);
                end
                prev_stall = o_valid && !i_ready;
                prev_data  = o_data;
                prev_last  = o_last;
                if (o_done) done_total++;
            end
        end
    end

    task automatic start_pulse(input int addr, input int nb, input int bl, input int nac);
        @(posedge sd_clk); #2;
        i_addr = addr[9:0]; i_nblocks = nb[15:0]; i_blklen = bl[7:0]; i_nac = nac[7:0];
        i_start = 1'b1;
        @(posedge sd_clk); #2;
        i_start = 1'b0;
    endtask

    task automatic push_exp(input int addr, input int nb, input int bl);
        for (int b = 0; b < nb; b++)
            for (int k = 0; k < bl; k++)
                exp_q.push_back({(k == bl - 1), mem[(addr + b * bl + k) % 1024]});
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        do begin
            @(negedge sd_clk); #1; n++;
        end while (!o_done && n < 4000);
        chk(o_done, {nm, "_done_seen"}, n, 4000);
    endtask

    task automatic run_xfer(input string nm, input int addr, input int nb, input int bl,
                            input int nac, input int mode, input int drain);
        int d0;
        ready_mode = mode; drain_len = drain; d0 = done_total;
        push_exp(addr, nb, bl);
        start_pulse(addr, nb, bl, nac);
        wait_done(nm);
        chk(o_blocks == nb[15:0], {nm, "_blocks"}, o_blocks, nb);
        chk(!o_err, {nm, "_err"}, o_err, 0);
        chk(exp_q.size() == 0, {nm, "_words_left"}, exp_q.size(), 0);
        @(negedge sd_clk); #1;
        chk(!o_done && !o_busy, {nm, "_done_width"}, {o_done, o_busy}, 0);
        chk(done_total == d0 + 1, {nm, "_done_count"}, done_total - d0, 1);
        exp_q.delete();
    endtask

    task automatic bad_req(input string nm, input int bl, input int nb);
        int r0;
        r0 = rd_total;
        start_pulse(5, nb, bl, 2);
        @(negedge sd_clk); #1;
        chk(!o_done && o_err, {nm, "_cycle1"}, {o_done, o_err}, 1);
        @(negedge sd_clk); #1;
        chk(o_done && o_err && !o_busy, {nm, "_cycle2"}, {o_done, o_err, o_busy}, 6);
        @(negedge sd_clk); #1;
        chk(!o_done && o_err, {nm, "_after"}, {o_done, o_err}, 1);
        chk(rd_total == r0, {nm, "_no_reads"}, rd_total - r0, 0);
    endtask

    initial begin
        int w0, n;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst_n = 1'b0; i_start = 1'b0; i_addr = '0; i_nblocks = '0;
        i_blklen = '0; i_nac = '0; i_stop = 1'b0;
        repeat (3) @(negedge sd_clk);
        #1 chk(outs == '0, "reset_outputs", $countones(outs), 0);
        @(posedge sd_clk); #2 rst_n = 1'b1;
        repeat (2) @(posedge sd_clk);

        run_xfer("normal", 'h3FE, 2, 4, 3, 0, 0);
        run_xfer("backpressure", 100, 2, 5, 1, 1, 0);
        run_xfer("drain_gate", 700, 2, 4, 2, 0, 20);
        bad_req("blklen0", 0, 1);
        bad_req("blklen129", 129, 1);
        run_xfer("max_len", 900, 1, 128, 0, 2, 1);

`ifdef SDTX_SEQ_STOP_EN
        ready_mode = 0; drain_len = 0;
        push_exp(50, 3, 4);
        w0 = words_hs;
        start_pulse(50, 0, 4, 1);
        n = 0;
        while (words_hs < w0 + 10 && n < 2000) begin
            @(negedge sd_clk); #1; n++;
        end
        chk(n < 2000, "stop_reach_blk3", n, 2000);
        @(posedge sd_clk); #2 i_stop = 1'b1;
        @(posedge sd_clk); #2 i_stop = 1'b0;
        wait_done("stop");
        chk(o_blocks == 16'd3, "stop_blocks", o_blocks, 3);
        chk(!o_err, "stop_err", o_err, 0);
        chk(exp_q.size() == 0, "stop_words_left", exp_q.size(), 0);
        exp_q.delete();
`else
        bad_req("nblocks0", 4, 0);
`endif

        for (int t = 0; t < 6; t++) begin
            run_xfer("random", $urandom % 1024, $urandom_range(1, 3),
                     ($urandom % 5 == 0) ? 128 : $urandom_range(1, 8),
                     $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        ready_mode = 0; drain_len = 0;
        push_exp(300, 1, 32);
        w0 = words_hs;
        start_pulse(300, 1, 32, 0);
        n = 0;
        while (words_hs < w0 + 5 && n < 500) begin
            @(negedge sd_clk); #1; n++;
        end
        chk(n < 500, "abort_reach_stream", n, 500);
        @(posedge sd_clk); #3 rst_n = 1'b0;
        #1 chk(outs == '0, "abort_outputs", $countones(outs), 0);
        exp_q.delete();
        repeat (3) @(posedge sd_clk);
        #2 rst_n = 1'b1;
        run_xfer("after_abort", 310, 2, 6, 1, 2, 2);

        repeat (5) @(posedge sd_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
